m6800_cycle_gen: RTL and testbench

Parametrised successor to the fixed 6800-style synchronous bus engine used on the accelerator.
- Generates the E clock from C7M with configurable period and duty.
- Handles the VPA-initiated synchronous cycle, driving VMA_n and a local DTACK at configurable points relative to E.
- Adds input synchronisers, mid-cycle abort, an E-fall strobe and a busy flag.
- Sits between the CPU-side strobes and the motherboard. M6800_DTACK_n is ANDed into the CPU DTACK at top level.

---
 rtl/m6800_cycle_gen.sv | 118 +++++++++++
 tb/tb_m6800_cycle_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/m6800_cycle_gen.sv
// 6800-style E clock and VPA synchronous-cycle engine; all outputs registered, inputs see SYNC_STAGES of latency.
// No backpressure: E runs free, a cycle follows E timing and ends when the CPU strobe drops.
module m6800_cycle_gen #(
    parameter int E_DIV       = 10,
    parameter int E_HIGH      = 4,
    parameter int VMA_LEAD    = 2,
    parameter int DTACK_LEAD  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic C7M,
    input  logic RESET_n,
    input  logic AS_CPU_n,
    input  logic VPA_n,
    input  logic CPUSPACE,
    output logic E_OUT,
    output logic E_FALL,
    output logic VMA_n,
    output logic M6800_DTACK_n,
    output logic BUSY
);
    localparam int CW = $clog2(E_DIV);
    localparam logic [CW-1:0] ECNT_MAX  = CW'(E_DIV - 1);
    localparam logic [CW-1:0] E_RISE    = CW'(E_DIV - E_HIGH);
    localparam logic [CW-1:0] VMA_POS   = CW'(E_DIV - E_HIGH - VMA_LEAD);
    localparam logic [CW-1:0] DTACK_POS = CW'(E_DIV - DTACK_LEAD);

    typedef enum logic [2:0] {IDLE, WAIT_E, VMA_ACT, DTACK_ACT, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          ecnt_q, ecnt_d;
    logic                   e_out_q, e_out_d;
    logic                   e_fall_q, e_fall_d;
    logic                   vma_n_q, vma_n_d;
    logic                   dtack_n_q, dtack_n_d;
    logic                   busy_q, busy_d;
    logic [SYNC_STAGES-1:0] as_sync_q, as_sync_d;
    logic [SYNC_STAGES-1:0] vpa_sync_q, vpa_sync_d;
    logic                   as_s, vpa_s, req;

    assign as_s  = as_sync_q[SYNC_STAGES-1];
    assign vpa_s = vpa_sync_q[SYNC_STAGES-1];
    assign req   = !as_s && !vpa_s && !CPUSPACE;

    // Outputs are registered, so every decision looks at the count of the coming cycle.
    always_comb begin
        ecnt_d        = (ecnt_q == ECNT_MAX) ? '0 : ecnt_q + CW'(1);
        e_out_d       = (ecnt_d >= E_RISE);
        e_fall_d      = (ecnt_d == '0);
        as_sync_d[0]  = AS_CPU_n;
        vpa_sync_d[0] = VPA_n;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            as_sync_d[i]  = as_sync_q[i-1];
            vpa_sync_d[i] = vpa_sync_q[i-1];
        end
    end

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q    <= IDLE;
            ecnt_q     <= '0;
            e_out_q    <= 1'b0;
            e_fall_q   <= 1'b0;
            vma_n_q    <= 1'b1;
            dtack_n_q  <= 1'b1;
            busy_q     <= 1'b0;
            as_sync_q  <= '1;
            vpa_sync_q <= '1;
        end else begin
            state_q    <= state_d;
            ecnt_q     <= ecnt_d;
            e_out_q    <= e_out_d;
            e_fall_q   <= e_fall_d;
            vma_n_q    <= vma_n_d;
            dtack_n_q  <= dtack_n_d;
            busy_q     <= busy_d;
            as_sync_q  <= as_sync_d;
            vpa_sync_q <= vpa_sync_d;
        end
    end

    // A strobe drop aborts ahead of any E-position event landing on the same clock.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) state_d = (ecnt_d == VMA_POS) ? VMA_ACT : WAIT_E;
            end
            WAIT_E: begin
                if (as_s)                    state_d = IDLE;
                else if (ecnt_d == VMA_POS)  state_d = VMA_ACT;
            end
            VMA_ACT: begin
                if (as_s)                    state_d = IDLE;
                else if (ecnt_d == DTACK_POS) state_d = DTACK_ACT;
            end
            DTACK_ACT: begin
                if (as_s)                    state_d = IDLE;
                else if (ecnt_d == '0)       state_d = RELEASE;
            end
            RELEASE: begin
                if (as_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vma_n_d   = !(state_d == VMA_ACT || state_d == DTACK_ACT);
        dtack_n_d = !(state_d == DTACK_ACT || state_d == RELEASE);
        busy_d    = (state_d != IDLE);
    end

    assign E_OUT         = e_out_q;
    assign E_FALL        = e_fall_q;
    assign VMA_n         = vma_n_q;
    assign M6800_DTACK_n = dtack_n_q;
    assign BUSY          = busy_q;
endmodule

// File: tb/tb_m6800_cycle_gen.sv
// Bench for m6800_cycle_gen: default instance (single sync stage) and a 20-clock E instance.
// Expected bus levels are queued per cycle when stimulus is driven and compared as cycles elapse.
module tb_m6800_cycle_gen;
    logic C7M = 1'b0;
    logic RESET_n = 1'b1;
    logic as_a = 1'b1, vpa_a = 1'b1, cpus_a = 1'b0;
    logic as_b = 1'b1, vpa_b = 1'b1, cpus_b = 1'b0;
    logic e_a, efall_a, vma_a, dtack_a, busy_a;
    logic e_b, efall_b, vma_b, dtack_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int pe      = 0;

    typedef struct {
        int    cyc;
        string tag;
        logic  vma_n;
        logic  dtack_n;
        logic  busy;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    m6800_cycle_gen #(.SYNC_STAGES(1)) dut_a (
        .C7M(C7M), .RESET_n(RESET_n), .AS_CPU_n(as_a), .VPA_n(vpa_a), .CPUSPACE(cpus_a),
        .E_OUT(e_a), .E_FALL(efall_a), .VMA_n(vma_a), .M6800_DTACK_n(dtack_a), .BUSY(busy_a)
    );

    m6800_cycle_gen #(.E_DIV(20), .E_HIGH(8), .VMA_LEAD(3), .DTACK_LEAD(2), .SYNC_STAGES(2)) dut_b (
        .C7M(C7M), .RESET_n(RESET_n), .AS_CPU_n(as_b), .VPA_n(vpa_b), .CPUSPACE(cpus_b),
        .E_OUT(e_b), .E_FALL(efall_b), .VMA_n(vma_b), .M6800_DTACK_n(dtack_b), .BUSY(busy_b)
    );

    initial forever #5 C7M = ~C7M;

    always @(posedge C7M) cyc <= cyc + 1;

    // Edges since reset release: equals the DUT's E count modulo E_DIV.
    always @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) pe <= 0;
        else          pe <= pe + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push(input bit b, input int c, input string tag,
                                 input logic v, input logic d, input logic bu);
        exp_t e;
        e.cyc = c; e.tag = tag; e.vma_n = v; e.dtack_n = d; e.busy = bu;
        if (b) begin
            if (q_b.size() > 0 && q_b[$].cyc >= c) return;
            q_b.push_back(e);
        end else begin
            if (q_a.size() > 0 && q_a[$].cyc >= c) return;
            q_a.push_back(e);
        end
    endfunction

    always @(negedge C7M) begin
        exp_t e;
        chk("a_e_out",  e_a,     int'((pe % 10) >= 6));
        chk("a_e_fall", efall_a, int'((pe % 10) == 0 && pe != 0));
        chk("b_e_out",  e_b,     int'((pe % 20) >= 12));
        chk("b_e_fall", efall_b, int'((pe % 20) == 0 && pe != 0));
        while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
            e = q_a.pop_front();
            chk({"a_", e.tag, "_when"},  cyc,     e.cyc);
            chk({"a_", e.tag, "_vma"},   vma_a,   e.vma_n);
            chk({"a_", e.tag, "_dtack"}, dtack_a, e.dtack_n);
            chk({"a_", e.tag, "_busy"},  busy_a,  e.busy);
        end
        while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
            e = q_b.pop_front();
            chk({"b_", e.tag, "_when"},  cyc,     e.cyc);
            chk({"b_", e.tag, "_vma"},   vma_b,   e.vma_n);
            chk({"b_", e.tag, "_dtack"}, dtack_b, e.dtack_n);
            chk({"b_", e.tag, "_busy"},  busy_b,  e.busy);
        end
    end

    task automatic drv(input bit b, input logic as_v, input logic vpa_v);
        if (b) begin as_b = as_v; vpa_b = vpa_v; end
        else   begin as_a = as_v; vpa_a = vpa_v; end
    endtask

    task automatic wait_ecnt(input int e, input int k);
        int n = 0;
        @(negedge C7M);
        while ((pe % e) != k && n < 100) begin
            @(negedge C7M);
            n++;
        end
        chk("wait_ecnt", int'(n < 100), 1);
    endtask

    task automatic wait_cyc(input int t);
        int n = 0;
        while (cyc < t && n < 200) begin
            @(negedge C7M);
            n++;
        end
        chk("wait_cyc", int'(cyc >= t), 1);
    endtask

    task automatic drain(input bit b);
        int n = 0;
        while ((b ? q_b.size() : q_a.size()) != 0 && n < 100) begin
            @(negedge C7M);
            n++;
        end
        chk(b ? "drain_b" : "drain_a", b ? q_b.size() : q_a.size(), 0);
    endtask

    // k: E count at which the synchronised request is first seen.
    // ab > 0: strobe seen high again at that count; -1: normal end; -2: reset during DTACK.
    task automatic req_cycle(input bit b, input int k, input int ab);
        int e, vp, dp, s, x, r, v, d, vr, a;
        e  = b ? 20 : 10;
        vp = b ? 9  : 4;
        dp = b ? 18 : 9;
        s  = b ? 2  : 1;
        wait_ecnt(e, (k - s + e) % e);
        x = cyc;
        drv(b, 1'b0, 1'b0);
        r  = x + s;
        v  = (k <= vp - 1) ? r - k + vp : r - k + e + vp;
        d  = v - vp + dp;
        vr = v - vp + e;
        push(b, r,     "req_seen", 1'b1, 1'b1, 1'b0);
        push(b, r + 1, "wait_e",   (r + 1 == v) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        push(b, v - 1, "pre_vma",  1'b1, 1'b1, 1'b1);
        push(b, v,     "vma_fall", 1'b0, 1'b1, 1'b1);
        if (ab > 0) begin
            a = v - vp + ab;
            push(b, a,     "abort_seen", 1'b0, (ab >= dp) ? 1'b0 : 1'b1, 1'b1);
            push(b, a + 1, "abort_idle", 1'b1, 1'b1, 1'b0);
            push(b, a + 2, "abort_hold", 1'b1, 1'b1, 1'b0);
            wait_cyc(a - s);
            drv(b, 1'b1, 1'b1);
        end else begin
            push(b, d - 1, "pre_dtack",  1'b0, 1'b1, 1'b1);
            push(b, d,     "dtack_fall", 1'b0, 1'b0, 1'b1);
            if (ab == -2) begin
                wait_cyc(d);
                #1 RESET_n = 1'b0;
                #1;
                chk("rst_vma",    b ? vma_b   : vma_a,   1);
                chk("rst_dtack",  b ? dtack_b : dtack_a, 1);
                chk("rst_busy",   b ? busy_b  : busy_a,  0);
                chk("rst_e_out",  b ? e_b     : e_a,     0);
                chk("rst_e_fall", b ? efall_b : efall_a, 0);
                drv(b, 1'b1, 1'b1);
                repeat (3) @(negedge C7M);
                #1 RESET_n = 1'b1;
            end else begin
                push(b, vr - 1, "pre_vma_rise", 1'b0, 1'b0, 1'b1);
                push(b, vr,     "vma_rise",     1'b1, 1'b0, 1'b1);
                wait_cyc(vr + 1);
                x = cyc;
                drv(b, 1'b1, 1'b1);
                push(b, x + s,     "release_seen", 1'b1, 1'b0, 1'b1);
                push(b, x + s + 1, "released",     1'b1, 1'b1, 1'b0);
            end
        end
        drain(b);
    endtask

    task automatic cpuspace_test();
        int x;
        wait_ecnt(10, 0);
        x = cyc;
        cpus_a = 1'b1;
        drv(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 30; i++) push(1'b0, x + i, "cpuspace", 1'b1, 1'b1, 1'b0);
        wait_cyc(x + 30);
        drv(1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge C7M);
        cpus_a = 1'b0;
        drain(1'b0);
    endtask

    initial begin
        int ks_a[4];
        int abs_a[3];
        int ks_b[3];
        ks_a  = '{2, 5, 4, 3};
        abs_a = '{6, 8, 9};
        ks_b  = '{5, 8, 9};
        #1 RESET_n = 1'b0;
        repeat (2) @(negedge C7M);
        chk("reset_vma_a",   vma_a,   1);
        chk("reset_dtack_a", dtack_a, 1);
        chk("reset_busy_a",  busy_a,  0);
        chk("reset_vma_b",   vma_b,   1);
        chk("reset_dtack_b", dtack_b, 1);
        chk("reset_busy_b",  busy_b,  0);
        #1 RESET_n = 1'b1;

        foreach (ks_a[i])  req_cycle(1'b0, ks_a[i], -1);
        cpuspace_test();
        foreach (abs_a[i]) req_cycle(1'b0, 2, abs_a[i]);
        req_cycle(1'b0, 2, -2);
        req_cycle(1'b0, 2, -1);
        foreach (ks_b[i])  req_cycle(1'b1, ks_b[i], -1);

        repeat (5) @(negedge C7M);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
